// File: rtl/credit_rr_arbiter.sv
// rtl/credit_rr_arbiter.sv - round-robin arbiter sharing a credit pool, with drain/quiesce FSM
module credit_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int CREDITS = 8,
    localparam int CW     = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    input  logic             ret,
    input  logic             drain_req,
    output logic             drain_done,
    output logic [CW-1:0]    credits,
    output logic             credit_avail,
    output logic             credit_ovf
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DRAINED
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] credits_q, credits_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          drain_done_q;

    logic [N_REQ-1:0] gnt_sel;
    logic [PW-1:0]    win_idx;
    logic [PW:0]      sum;
    logic [PW-1:0]    idx;
    logic             found;
    logic             grant_en;
    logic             fire;

    // Round-robin search from the pointer, wrapping, first asserted request wins
    always_comb begin
        gnt_sel = '0;
        win_idx = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (sum >= (PW+1)'(N_REQ)) begin
                sum = sum - (PW+1)'(N_REQ);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt_sel[idx] = 1'b1;
                win_idx      = idx;
            end
        end
    end

    // Grants only in RUN, without a pending drain, using the registered credit count
    always_comb begin
        grant_en = !rst && (state_q == ST_RUN) && !drain_req && (credits_q != '0);
        gnt      = grant_en ? gnt_sel : '0;
        fire     = |(req & gnt);
    end

    // Pointer advance, credit up/down with saturation at full, sticky overflow
    always_comb begin
        ptr_d     = ptr_q;
        credits_d = credits_q;
        ovf_d     = ovf_q;
        if (fire) begin
            ptr_d = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
        end
        if (fire && !ret) begin
            credits_d = credits_q - CW'(1);
        end else if (!fire && ret) begin
            if (credits_q == FULL) begin
                ovf_d = 1'b1;
            end else begin
                credits_d = credits_q + CW'(1);
            end
        end
    end

    // Drain FSM next state: wait for the pool to refill before reporting quiesced
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (drain_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!drain_req)              state_d = ST_RUN;
                else if (credits_q == FULL)  state_d = ST_DRAINED;
            end
            ST_DRAINED: begin
                if (!drain_req) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            credits_q    <= FULL;
            ovf_q        <= 1'b0;
            ptr_q        <= '0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            credits_q    <= credits_d;
            ovf_q        <= ovf_d;
            ptr_q        <= ptr_d;
            drain_done_q <= (state_d == ST_DRAINED);
        end
    end

    assign credits      = credits_q;
    assign credit_avail = (credits_q != '0);
    assign credit_ovf   = ovf_q;
    assign drain_done   = drain_done_q;

endmodule
